// File: rtl/fixpoint_pkg.sv
// Shared types for the fixpoint iteration checker.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package fixpoint_pkg;

    // Engine control states: waiting for a request, stepping, presenting a result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_HOLD = 2'd2
    } fp_state_e;

endpackage

// File: rtl/fixpoint_step.sv
// One propagation step of the monotone cell system: nxt = cur | (rotl(cur) & en & ~blk).
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   cur  in  WIDTH  current state
//   en   in  WIDTH  cells that may be set by propagation
//   blk  in  WIDTH  cells blocked from propagation (overrides en)
//   nxt  out WIDTH  state after one step
//   eq   out 1      nxt == cur (fixpoint reached)
module fixpoint_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] blk,
    output logic [WIDTH-1:0] nxt,
    output logic             eq
);

    logic [WIDTH-1:0] prop;

    // Rotate-left: each cell sees its lower neighbour, bit WIDTH-1 wraps into bit 0.
    assign prop = {cur[WIDTH-2:0], cur[WIDTH-1]};
    assign nxt  = cur | (prop & en & ~blk);
    assign eq   = (nxt == cur);

endmodule

// File: rtl/fixpoint_iter_checker.sv
// Iterates the propagation step from a seed until a fixpoint or MAX_ITER state changes.
// Latency: accept edge to res_valid = res_iters+2 cycles (fixpoint) or MAX_ITER+2 (timeout).
// Backpressure: start_ready only in IDLE; result held stable until res_valid & res_ready.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start_valid/start_ready  request handshake; seed and masks latched on acceptance
//   seed, en_mask, blk_mask  initial state and propagation masks
//   bad_val, bad_mask        pattern compared against the fixpoint
//   res_valid/res_ready      result handshake
//   res_state, res_iters     final state and number of state-changing steps
//   res_fix, res_bad         fixpoint reached; fixpoint matches masked bad pattern
module fixpoint_iter_checker
    import fixpoint_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int MAX_ITER = WIDTH,
    localparam int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  seed,
    input  logic [WIDTH-1:0]  en_mask,
    input  logic [WIDTH-1:0]  blk_mask,
    input  logic [WIDTH-1:0]  bad_val,
    input  logic [WIDTH-1:0]  bad_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_state,
    output logic [ITER_W-1:0] res_iters,
    output logic              res_fix,
    output logic              res_bad
);

    localparam logic [ITER_W-1:0] CNT_MAX = ITER_W'(MAX_ITER);

    fp_state_e         state_q, state_d;
    logic [WIDTH-1:0]  cur_q, cur_d;
    logic [WIDTH-1:0]  en_q, en_d;
    logic [WIDTH-1:0]  blk_q, blk_d;
    logic [WIDTH-1:0]  bval_q, bval_d;
    logic [WIDTH-1:0]  bmask_q, bmask_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_state_q, res_state_d;
    logic [ITER_W-1:0] res_iters_q, res_iters_d;
    logic              res_fix_q, res_fix_d;
    logic              res_bad_q, res_bad_d;

    logic [WIDTH-1:0]  step_nxt;
    logic              step_eq;

    fixpoint_step #(.WIDTH(WIDTH)) u_step (
        .cur (cur_q),
        .en  (en_q),
        .blk (blk_q),
        .nxt (step_nxt),
        .eq  (step_eq)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        en_d        = en_q;
        blk_d       = blk_q;
        bval_d      = bval_q;
        bmask_d     = bmask_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_state_d = res_state_q;
        res_iters_d = res_iters_q;
        res_fix_d   = res_fix_q;
        res_bad_d   = res_bad_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    state_d = S_ITER;
                    cur_d   = seed;
                    en_d    = en_mask;
                    blk_d   = blk_mask;
                    bval_d  = bad_val;
                    bmask_d = bad_mask;
                    cnt_d   = '0;
                end
            end
            S_ITER: begin
                // Fixpoint is tested before the bound so it wins when both hold.
                if (step_eq) begin
                    state_d     = S_HOLD;
                    res_state_d = cur_q;
                    res_iters_d = cnt_q;
                    res_fix_d   = 1'b1;
                    res_bad_d   = (((cur_q ^ bval_q) & bmask_q) == '0);
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = S_HOLD;
                    res_state_d = cur_q;
                    res_iters_d = cnt_q;
                    res_fix_d   = 1'b0;
                    res_bad_d   = 1'b0;
                end else begin
                    cur_d = step_nxt;
                    cnt_d = cnt_q + ITER_W'(1);
                end
            end
            S_HOLD: begin
                // Result registers load on HOLD entry; valid follows one cycle later,
                // which gives the fixed iters+2 latency from the accept edge.
                if (res_valid_q && res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            en_q        <= '0;
            blk_q       <= '0;
            bval_q      <= '0;
            bmask_q     <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_state_q <= '0;
            res_iters_q <= '0;
            res_fix_q   <= 1'b0;
            res_bad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            en_q        <= en_d;
            blk_q       <= blk_d;
            bval_q      <= bval_d;
            bmask_q     <= bmask_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_state_q <= res_state_d;
            res_iters_q <= res_iters_d;
            res_fix_q   <= res_fix_d;
            res_bad_q   <= res_bad_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign res_valid   = res_valid_q;
    assign res_state   = res_state_q;
    assign res_iters   = res_iters_q;
    assign res_fix     = res_fix_q;
    assign res_bad     = res_bad_q;

endmodule

// File: tb/tb_fixpoint_iter_checker.sv
// Bench for fixpoint_iter_checker: directed requests push hand-computed results into
// per-instance queues; monitors pop and compare on each result handshake.
// Instance 0 uses the default bound (MAX_ITER=8), instance 1 uses MAX_ITER=4.
module tb_fixpoint_iter_checker;

    typedef struct {
        logic [7:0] st;
        int         it;
        logic       fix;
        logic       bad;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sv0 = 1'b0, sv1 = 1'b0;
    logic       rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] seed = '0, en = '0, blk = '0, bad_val = '0, bad_mask = '0;

    logic       start_ready0, start_ready1;
    logic       res_valid0, res_valid1;
    logic [7:0] res_state0, res_state1;
    logic [3:0] res_iters0;
    logic [2:0] res_iters1;
    logic       res_fix0, res_fix1, res_bad0, res_bad1;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic seen0 = 1'b0, seen1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fixpoint_iter_checker #(.WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(start_ready0),
        .seed(seed), .en_mask(en), .blk_mask(blk), .bad_val(bad_val), .bad_mask(bad_mask),
        .res_valid(res_valid0), .res_ready(rdy0), .res_state(res_state0),
        .res_iters(res_iters0), .res_fix(res_fix0), .res_bad(res_bad0)
    );

    fixpoint_iter_checker #(.WIDTH(8), .MAX_ITER(4)) dut1 (
        .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(start_ready1),
        .seed(seed), .en_mask(en), .blk_mask(blk), .bad_val(bad_val), .bad_mask(bad_mask),
        .res_valid(res_valid1), .res_ready(rdy1), .res_state(res_state1),
        .res_iters(res_iters1), .res_fix(res_fix1), .res_bad(res_bad1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors sample 2 time units after the falling edge so they see this cycle's ready.
    always @(negedge clk) begin
        #2;
        if (!res_valid0) seen0 = 1'b0;
        else if (!seen0) begin
            seen0 = 1'b1;
            if (q0.size() == 0) chk("unexpected_res0", 1, 0);
            else chk("latency0", cyc - q0[0].acc, q0[0].lat);
        end
        if (res_valid0 && rdy0 && q0.size() > 0) begin
            exp_t x;
            x = q0.pop_front();
            chk("state0", res_state0, x.st);
            chk("iters0", res_iters0, x.it);
            chk("fix0", res_fix0, x.fix);
            chk("bad0", res_bad0, x.bad);
        end
    end

    always @(negedge clk) begin
        #2;
        if (!res_valid1) seen1 = 1'b0;
        else if (!seen1) begin
            seen1 = 1'b1;
            if (q1.size() == 0) chk("unexpected_res1", 1, 0);
            else chk("latency1", cyc - q1[0].acc, q1[0].lat);
        end
        if (res_valid1 && rdy1 && q1.size() > 0) begin
            exp_t x;
            x = q1.pop_front();
            chk("state1", res_state1, x.st);
            chk("iters1", res_iters1, x.it);
            chk("fix1", res_fix1, x.fix);
            chk("bad1", res_bad1, x.bad);
        end
    end

    // Called at a falling edge. Presents one request for one cycle, then scrambles the
    // inputs so that any use of unlatched masks shows up as a wrong result.
    task automatic issue(input int inst, input logic [7:0] s, e, b, bv, bm,
                         input logic [7:0] xs, input int xi, input logic xf, xb,
                         input int xlat);
        exp_t x;
        int   t;
        t = 0;
        while (!(inst == 0 ? start_ready0 : start_ready1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("start_ready_timeout", 0, 1);
            return;
        end
        seed = s; en = e; blk = b; bad_val = bv; bad_mask = bm;
        x.st = xs; x.it = xi; x.fix = xf; x.bad = xb; x.lat = xlat; x.acc = cyc + 1;
        if (inst == 0) begin q0.push_back(x); sv0 = 1'b1; end
        else           begin q1.push_back(x); sv1 = 1'b1; end
        @(negedge clk);
        sv0 = 1'b0; sv1 = 1'b0;
        seed = 8'hA5; en = 8'h5A; blk = 8'hC3; bad_val = 8'h3C; bad_mask = 8'h99;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        // Reset values, sampled while reset is still asserted.
        chk("rst_start_ready", start_ready0, 1);
        chk("rst_res_valid", res_valid0, 0);
        chk("rst_res_state", res_state0, 0);
        chk("rst_res_iters", res_iters0, 0);
        chk("rst_res_fix", res_fix0, 0);
        chk("rst_res_bad", res_bad0, 0);
        rst = 1'b0;
        @(negedge clk);

        //     inst seed   en     blk    bad_val bad_mask  state  it fix bad lat
        issue(0, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01,    8'hFF, 7, 1, 0, 9);  // full fill
        issue(0, 8'h00, 8'hAA, 8'h55, 8'h00, 8'hFF,    8'h00, 0, 1, 1, 2);  // zero seed
        issue(0, 8'h01, 8'hFF, 8'h10, 8'h0F, 8'hFF,    8'h0F, 3, 1, 1, 5);  // blocked cell
        issue(0, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00,    8'h81, 1, 1, 1, 3);  // wrap 7 -> 0
        issue(1, 8'h01, 8'hFF, 8'h00, 8'h1F, 8'hFF,    8'h1F, 4, 0, 0, 6);  // timeout
        issue(1, 8'h01, 8'h1F, 8'h00, 8'h1F, 8'hFF,    8'h1F, 4, 1, 1, 6);  // fix at bound
        drain();

        // Result held under backpressure; a start during HOLD must be ignored.
        rdy0 = 1'b0;
        issue(0, 8'h03, 8'hFF, 8'h00, 8'hFF, 8'h0F,    8'hFF, 6, 1, 1, 8);
        t = 0;
        while (!res_valid0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hold_valid_seen", res_valid0, 1);
        for (int k = 0; k < 5; k++) begin
            sv0 = (k == 2);
            if (k == 2) begin seed = 8'h01; en = 8'hFF; blk = 8'h00; end
            chk("hold_valid", res_valid0, 1);
            chk("hold_state", res_state0, 8'hFF);
            chk("hold_iters", res_iters0, 6);
            chk("hold_fix", res_fix0, 1);
            chk("hold_start_ready", start_ready0, 0);
            @(negedge clk);
        end
        sv0 = 1'b0;
        rdy0 = 1'b1;
        @(negedge clk);
        chk("valid_drop", res_valid0, 0);
        chk("ready_return", start_ready0, 1);
        chk("state_kept", res_state0, 8'hFF);

        // Reset in the middle of ITER aborts with no result.
        seed = 8'h01; en = 8'hFF; blk = 8'h00;
        sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        chk("iter_busy", start_ready0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", res_valid0, 0);
        chk("abort_start_ready", start_ready0, 1);
        chk("abort_state", res_state0, 0);
        chk("abort_iters", res_iters0, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_result", res_valid0, 0);
        chk("queues_empty", q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
